// File: rtl/div_pkg.sv
// Shared state encoding and arithmetic helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_END  = 2'd2
  } state_t;

  // Widest operand the negate helper supports; callers truncate to their own width.
  localparam int unsigned MAX_W = 128;

  // Conditional two's-complement negate; the low W bits of the result are the
  // W-bit negation of the low W bits of x, so callers cast back to W bits.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic en);
    return en ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift, trial subtract, restore, quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           q_bit;

  // rem_i < dvs_i holds every step, so bit WIDTH of the trial is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, dvd_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    q_bit   = ~trial[WIDTH];
    rem_o   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_o   = {dvd_i[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/iter_divider_param.sv
// Parametrised signed/unsigned restoring divider, one quotient bit per cycle.
module iter_divider_param
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             out_valid,
  output logic             stall
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             signed_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] dvd_abs_d;
  logic [WIDTH-1:0] dvs_abs_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_fin_d;
  logic [WIDTH-1:0] rem_fin_d;
  logic             dbz_d;

  // Operand magnitudes captured on accept; MIN_INT wraps to itself, read as unsigned.
  always_comb begin
    dvd_abs_d = WIDTH'(cond_neg(MAX_W'(dividend), is_signed & dividend[WIDTH-1]));
    dvs_abs_d = WIDTH'(cond_neg(MAX_W'(divisor), is_signed & divisor[WIDTH-1]));
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .dvd_i(dvd_q),
    .dvs_i(dvs_q),
    .rem_o(rem_d),
    .dvd_o(dvd_d)
  );

  // Sign-corrected results of the final iteration. With a zero divisor every trial
  // succeeds, so the remainder magnitude is |dividend| and re-applying its sign
  // restores the original dividend bits; only the quotient needs overriding.
  always_comb begin
    dbz_d     = (dvs_q == '0);
    quo_fin_d = dbz_d ? '1 : WIDTH'(cond_neg(MAX_W'(dvd_d), signed_q & qneg_q));
    rem_fin_d = WIDTH'(cond_neg(MAX_W'(rem_d), signed_q & rneg_q));
  end

  // Control FSM and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      signed_q    <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            signed_q <= is_signed;
            qneg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q   <= dividend[WIDTH-1];
            dvd_q    <= dvd_abs_d;
            dvs_q    <= dvs_abs_d;
            rem_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_OP;
          end
        end
        S_OP: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            quotient_q  <= quo_fin_d;
            remainder_q <= rem_fin_d;
            dbz_q       <= dbz_d;
            out_valid_q <= 1'b1;
            state_q     <= S_END;
          end
        end
        S_END: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign out_valid   = out_valid_q;
  assign stall       = (state_q == S_OP) || ((state_q == S_IDLE) && in_valid);

endmodule

// File: tb/tb_iter_divider_param.sv
// Bench for iter_divider_param: directed 32-bit cases plus a random 8-bit sweep.
module tb_iter_divider_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid  [2];
  logic        is_signed [2];
  logic [31:0] dvd       [2];
  logic [31:0] dvs       [2];

  logic [31:0] q32, r32;
  logic        dz32, ov32, st32;
  logic [7:0]  q8, r8;
  logic        dz8, ov8, st8;

  iter_divider_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .is_signed(is_signed[0]),
    .dividend(dvd[0]), .divisor(dvs[0]), .quotient(q32), .remainder(r32),
    .div_by_zero(dz32), .out_valid(ov32), .stall(st32)
  );

  iter_divider_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .is_signed(is_signed[1]),
    .dividend(dvd[1][7:0]), .divisor(dvs[1][7:0]), .quotient(q8), .remainder(r8),
    .div_by_zero(dz8), .out_valid(ov8), .stall(st8)
  );

  logic [31:0] act_q [2];
  logic [31:0] act_r [2];
  logic        act_dz[2];
  logic        act_ov[2];
  logic        act_st[2];
  assign act_q[0] = q32;          assign act_q[1] = 32'(q8);
  assign act_r[0] = r32;          assign act_r[1] = 32'(r8);
  assign act_dz[0] = dz32;        assign act_dz[1] = dz8;
  assign act_ov[0] = ov32;        assign act_ov[1] = ov8;
  assign act_st[0] = st32;        assign act_st[1] = st8;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int w_of(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  // Reference division from the arithmetic rules: {div_by_zero, quotient, remainder}.
  function automatic logic [64:0] ref_div(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sgn);
    longint      m, sa, sb;
    logic [31:0] q, r;
    m = (longint'(1) <<< w) - 1;
    if (b == 32'd0) return {1'b1, 32'(m), a};
    if (sgn) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) <<< w);
      if (b[w-1]) sb = sb - (longint'(1) <<< w);
      q = 32'((sa / sb) & m);
      r = 32'((sa % sb) & m);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Transaction-level model: an accepted request completes W+1 cycles later.
  int          cyc = 0;
  bit          pend [2];
  int          due  [2];
  bit [64:0]   res  [2];
  bit [31:0]   hq   [2];
  bit [31:0]   hr   [2];
  bit          hdz  [2];
  int          n_acc[2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend[d] <= 1'b0;
        hq[d]   <= '0;
        hr[d]   <= '0;
        hdz[d]  <= 1'b0;
      end else if (pend[d]) begin
        if (cyc == due[d] - 1) begin
          hdz[d] <= res[d][64];
          hq[d]  <= res[d][63:32];
          hr[d]  <= res[d][31:0];
        end
        if (cyc == due[d]) pend[d] <= 1'b0;
      end else if (in_valid[d]) begin
        pend[d]  <= 1'b1;
        due[d]   <= cyc + w_of(d) + 1;
        res[d]   <= ref_div(w_of(d), dvd[d], dvs[d], is_signed[d]);
        n_acc[d] <= n_acc[d] + 1;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d out_valid", d), 32'(act_ov[d]), 32'(pend[d] && (cyc == due[d])));
        chk($sformatf("d%0d stall", d), 32'(act_st[d]),
            32'(pend[d] ? (cyc < due[d]) : in_valid[d]));
        chk($sformatf("d%0d quotient", d), act_q[d], hq[d]);
        chk($sformatf("d%0d remainder", d), act_r[d], hr[d]);
        chk($sformatf("d%0d div_by_zero", d), 32'(act_dz[d]), 32'(hdz[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one 32-bit division, optionally poke in_valid while busy, then check
  // the latency and the result against hand-computed values.
  task automatic run32(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic noise, input logic [31:0] eq,
                       input logic [31:0] er, input logic edz);
    int n;
    in_valid[0]  = 1'b1;
    dvd[0]       = a;
    dvs[0]       = b;
    is_signed[0] = sgn;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (ov32) break;
      in_valid[0]  = noise && (n % 2 == 0);
      dvd[0]       = $urandom;
      dvs[0]       = $urandom;
      is_signed[0] = 1'($urandom_range(0, 1));
    end
    chk({nm, " latency"}, 32'(n), 32'd33);
    chk({nm, " q"}, q32, eq);
    chk({nm, " r"}, r32, er);
    chk({nm, " dz"}, 32'(dz32), 32'(edz));
    in_valid[0] = 1'b0;
    step();
  endtask

  function automatic logic [31:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 32'h00;
      1:       return 32'h80;
      2:       return 32'hFF;
      3:       return 32'h01;
      4:       return 32'h7F;
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; is_signed[d] = 1'b0; dvd[d] = '0; dvs[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset q", q32, 32'h0);
    chk("reset r", r32, 32'h0);
    chk("reset stall", 32'(st32), 32'h0);
    chk("reset out_valid", 32'(ov32), 32'h0);

    run32("u100/7",   32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         32'd2,          1'b0);
    run32("s-7/2",    32'hFFFFFFF9,   32'h2,          1'b1, 1'b0, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
    run32("u-7/2",    32'hFFFFFFF9,   32'h2,          1'b0, 1'b0, 32'h7FFFFFFC,   32'h1,          1'b0);
    run32("s7/-2",    32'd7,          32'hFFFFFFFE,   1'b1, 1'b0, 32'hFFFFFFFD,   32'h1,          1'b0);
    run32("sovf",     32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b0, 32'h80000000,   32'h0,          1'b0);
    run32("umax/1",   32'hFFFFFFFF,   32'h1,          1'b0, 1'b0, 32'hFFFFFFFF,   32'h0,          1'b0);
    run32("s5/0",     32'd5,          32'd0,          1'b1, 1'b0, 32'hFFFFFFFF,   32'd5,          1'b1);
    run32("u5/0",     32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFFFFFF,   32'd5,          1'b1);
    run32("s-5/0",    32'hFFFFFFFB,   32'd0,          1'b1, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1);

    // Reset during the 10th busy cycle drops the operation.
    in_valid[0] = 1'b1; dvd[0] = 32'd1000; dvs[0] = 32'd3; is_signed[0] = 1'b0;
    step();
    in_valid[0] = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset q", q32, 32'h0);
    chk("midreset r", r32, 32'h0);
    chk("midreset dz", 32'(dz32), 32'h0);
    chk("midreset stall", 32'(st32), 32'h0);
    chk("midreset out_valid", 32'(ov32), 32'h0);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ov32) cycles++;
    end
    chk("midreset no pulse", 32'(cycles), 32'd0);
    run32("u9/3",     32'd9,          32'd3,          1'b0, 1'b0, 32'd3,          32'd0,          1'b0);
    run32("noisy",    32'd100,        32'd7,          1'b0, 1'b1, 32'd14,         32'd2,          1'b0);

    // Random 8-bit sweep, back-to-back and idle gaps mixed, checked by the model.
    cycles = 0;
    while (n_acc[1] < 2000 && cycles < 60000) begin
      in_valid[1]  = 1'($urandom_range(0, 1));
      is_signed[1] = 1'($urandom_range(0, 1));
      dvd[1]       = pick8();
      dvs[1]       = pick8();
      step();
      cycles++;
    end
    chk("sweep count", 32'(n_acc[1] >= 2000), 32'd1);
    in_valid[1] = 1'b0;
    repeat (12) step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
